staticio_bridge: RTL
====================

# staticio_bridge

Buffering and flow-control stage between the NES-side static I/O register logic and `staticio_uart`. Holds a 512-byte TX ring buffer that is drained into the UART one frame at a time, and a 512-byte RX ring buffer filled from UART receive events. The block supplies the ring buffers the UART itself does not have, and keeps CPU-side accesses single-cycle and non-blocking.

## Interface
- `DEPTH_LOG2`, 9: log2 of each ring buffer depth (512 entries).
- `clk` in 1: system clock, 21.477 MHz, shared with `staticio_uart`.
- `reset_n` in 1: asynchronous, active-low reset.
- `tx_wr` in 1: push strobe for `tx_data`.
- `tx_data` in 8: byte to transmit.
- `tx_full` out 1: TX buffer holds 2^DEPTH_LOG2 bytes.
- `tx_count` out DEPTH_LOG2+1: TX occupancy.
- `rx_rd` in 1: pop strobe for the RX head.
- `rx_data` out 8: RX head byte, first-word-fall-through.
- `rx_empty` out 1: RX buffer empty.
- `rx_count` out DEPTH_LOG2+1: RX occupancy.
- `err_clr` in 1: clears all sticky error flags.
- `tx_ovf`, `rx_ovf`, `frame_err` out 1 each: sticky flags for a TX push while full, an RX byte dropped while full, and an RX byte with stop bit 0.
- `uart_tdata` out 1: one-cycle load strobe to the UART (`tdata_i`).
- `uart_wdata` out 16: UART frame word (`data_i`).
- `uart_rdata` in 16: UART status/data word (`data_o`). Bit 13 is TBE, bit 12 is TSRE, bits 8:0 are the RX data with the stop bit in bit 8.
- `uart_rxint` in 1: one-cycle RX-complete pulse (`rxint`).

## Operation
- Both buffers are ring buffers with DEPTH_LOG2-bit read and write pointers that wrap modulo depth. Occupancy is a separate DEPTH_LOG2+1-bit counter.
- Full is defined as count == depth. Empty is defined as count == 0.
- A push while full is ignored and sets the matching overflow flag. A pop while empty is ignored and sets no flag.
- A simultaneous push and pop is legal. The count is unchanged. When the buffer was full before the cycle, the push is still rejected.
- TX FSM states:
  - T_IDLE: if the TX buffer is non-empty and `uart_rdata[13]` and `uart_rdata[12]` are both 1, go to T_LOAD.
  - T_LOAD: assert `uart_tdata` for exactly one cycle with `uart_wdata = {7'b0, 1'b1, head}`. Bit 8 is the stop bit and guarantees the UART shifts all 9 bits. Pop the head and go to T_START.
  - T_START: wait until TSRE == 0 (UART has accepted the frame), then go to T_BUSY.
  - T_BUSY: wait until TSRE == 1, then go to T_IDLE.
- `uart_wdata` holds its last value outside T_LOAD.
- RX path: on `uart_rxint`, sample `uart_rdata[8:0]`.
  - Bit 8 == 1: push bits 7:0 into the RX buffer. If the buffer is full, drop the byte and set `rx_ovf`.
  - Bit 8 == 0: drop the byte and set `frame_err`.
- `err_clr` clears all sticky flags. If `err_clr` and a new error occur in the same cycle, the flag ends up set.
- Reset values: pointers and counts 0, `tx_full` 0, `rx_empty` 1, all flags 0, `uart_tdata` 0, `uart_wdata` 16'h0000, TX FSM in T_IDLE.
- `rx_data` value is don't-care while `rx_empty` is 1.
- Asserting `reset_n` low mid-frame drops all buffered data immediately. The UART's own reset governs the frame already on the wire.

## Timing
- All outputs are registered except `rx_data`, which is an asynchronous read of the RX head.
- Push at edge N: the count and full/empty flags update at edge N.
- TX latency: `tx_wr` at edge N into an empty buffer with the UART idle drives `uart_tdata` high during cycle N+1 (T_IDLE decides at N+1, strobe is visible after N+1) and no earlier.
- Minimum spacing between `uart_tdata` pulses is one full UART frame: 10 bits × 688 clk at 31250 baud.
- RX latency: `uart_rxint` at edge N makes `rx_empty` fall and `rx_data` valid after edge N+1.
- Pop: `rx_rd` at edge N advances `rx_data` after edge N.

## Structure
- `staticio_pkg` holds:
  - the `DEPTH_LOG2` default;
  - the `tx_state_t` enum (T_IDLE, T_LOAD, T_START, T_BUSY);
  - UART word bit indices `UART_TBE_BIT=13`, `UART_TSRE_BIT=12`, `UART_STOP_BIT=8`.
- One sub-module, `staticio_fifo`, instantiated twice (TX and RX). It provides push, pop, full, empty, count and overflow, and its memory is inferred as distributed RAM with asynchronous read.

## Test plan
- **Reset:** hold `reset_n` low with random inputs → `rx_empty`=1, `tx_full`=0, counts 0, flags 0, `uart_tdata`=0, `uart_wdata`=16'h0000.
- **TX single byte:** UART model idle (TBE=TSRE=1); push 8'hA5 → exactly one `uart_tdata` pulse with `uart_wdata`=16'h01A5.
- **TX back-to-back:** push a second byte immediately after the first → it is issued only after TSRE falls and then rises again.
- **RX good/bad frames:**
  - `uart_rxint` with `uart_rdata[8:0]`=9'h15A → `rx_data`=8'h5A and `rx_count`=1.
  - Then 9'h05A → byte dropped, `frame_err`=1, count stays 1.
- **TX overflow:** hold TSRE=0 and push 513 bytes → `tx_full` asserts at byte 512, `tx_ovf`=1, count stays 512. `err_clr` clears `tx_ovf`.
- **RX wrap and simultaneous push/pop:**
  - Stream 600 bytes with interleaved pops → output order preserved across pointer wrap.
  - Push and pop in the same cycle at count 1 → count remains 1.
- **Reset mid-transfer:** pull `reset_n` low during T_BUSY → immediate return to T_IDLE with buffers empty.

Source files
------------

// File: rtl/staticio_pkg.sv
// Shared types and constants for the static I/O bridge between the NES
// register logic and staticio_uart.
package staticio_pkg;

  localparam int STATICIO_DEPTH_LOG2 = 9;

  // Bit positions inside the UART status/data word
  localparam int UART_TBE_BIT  = 13;
  localparam int UART_TSRE_BIT = 12;
  localparam int UART_STOP_BIT = 8;

  typedef enum logic [1:0] {
    T_IDLE  = 2'd0,
    T_LOAD  = 2'd1,
    T_START = 2'd2,
    T_BUSY  = 2'd3
  } tx_state_t;

  // The stop bit is forced high so the UART always shifts all nine bits.
  function automatic logic [15:0] tx_frame_word(input logic [7:0] data);
    return {7'b0, 1'b1, data};
  endfunction

endpackage

// File: rtl/staticio_fifo.sv
// Ring buffer with registered occupancy/flags and a first-word-fall-through
// head read straight out of distributed RAM.
module staticio_fifo
  import staticio_pkg::*;
#(
  parameter int DEPTH_LOG2 = STATICIO_DEPTH_LOG2,
  parameter int WIDTH      = 8
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  push,
  input  logic [WIDTH-1:0]      push_data,
  input  logic                  pop,
  output logic [WIDTH-1:0]      head_data,
  output logic                  full,
  output logic                  empty,
  output logic [DEPTH_LOG2:0]   count,
  output logic                  ovf
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0]   DEPTH_CNT = (DEPTH_LOG2 + 1)'(DEPTH);
  localparam logic [DEPTH_LOG2:0]   CNT_ONE   = (DEPTH_LOG2 + 1)'(1);
  localparam logic [DEPTH_LOG2-1:0] PTR_ONE   = DEPTH_LOG2'(1);

  logic [WIDTH-1:0]      mem_q [DEPTH];
  logic [DEPTH_LOG2-1:0] wr_ptr_q, wr_ptr_d;
  logic [DEPTH_LOG2-1:0] rd_ptr_q, rd_ptr_d;
  logic [DEPTH_LOG2:0]   count_q, count_d;
  logic                  full_q, full_d;
  logic                  empty_q, empty_d;
  logic                  push_ok, pop_ok;

  // A push is judged against the full state before the edge, so a push
  // colliding with a pop on a full buffer is still rejected.
  always_comb begin
    push_ok  = push && !full_q;
    pop_ok   = pop && !empty_q;
    wr_ptr_d = push_ok ? wr_ptr_q + PTR_ONE : wr_ptr_q;
    rd_ptr_d = pop_ok ? rd_ptr_q + PTR_ONE : rd_ptr_q;
    count_d  = count_q;
    if (push_ok && !pop_ok) begin
      count_d = count_q + CNT_ONE;
    end else if (!push_ok && pop_ok) begin
      count_d = count_q - CNT_ONE;
    end
    full_d  = (count_d == DEPTH_CNT);
    empty_d = (count_d == '0);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      full_q   <= 1'b0;
      empty_q  <= 1'b1;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      full_q   <= full_d;
      empty_q  <= empty_d;
    end
  end

  // No reset on the storage so it maps onto distributed RAM.
  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem_q[wr_ptr_q] <= push_data;
    end
  end

  assign head_data = mem_q[rd_ptr_q];
  assign full      = full_q;
  assign empty     = empty_q;
  assign count     = count_q;
  assign ovf       = push && full_q;

endmodule

// File: rtl/staticio_bridge.sv
// Buffering and flow control between the static I/O registers and
// staticio_uart: a TX ring drained one frame at a time, an RX ring fed by rxint.
module staticio_bridge
  import staticio_pkg::*;
#(
  parameter int DEPTH_LOG2 = STATICIO_DEPTH_LOG2
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  tx_wr,
  input  logic [7:0]            tx_data,
  output logic                  tx_full,
  output logic [DEPTH_LOG2:0]   tx_count,
  input  logic                  rx_rd,
  output logic [7:0]            rx_data,
  output logic                  rx_empty,
  output logic [DEPTH_LOG2:0]   rx_count,
  input  logic                  err_clr,
  output logic                  tx_ovf,
  output logic                  rx_ovf,
  output logic                  frame_err,
  output logic                  uart_tdata,
  output logic [15:0]           uart_wdata,
  input  logic [15:0]           uart_rdata,
  input  logic                  uart_rxint
);

  tx_state_t   tx_state_q, tx_state_d;
  logic        uart_tdata_q, uart_tdata_d;
  logic [15:0] uart_wdata_q, uart_wdata_d;
  logic        rx_valid_q, rx_valid_d;
  logic [8:0]  rx_frame_q, rx_frame_d;
  logic        tx_ovf_q, tx_ovf_d;
  logic        rx_ovf_q, rx_ovf_d;
  logic        frame_err_q, frame_err_d;

  logic        tx_pop, tx_empty, tx_push_ovf;
  logic [7:0]  tx_head;
  logic        rx_push, rx_bad_frame, rx_push_ovf, rx_full_unused;
  logic        uart_tbe, uart_tsre;
  logic        unused_rdata_bits;

  assign uart_tbe          = uart_rdata[UART_TBE_BIT];
  assign uart_tsre         = uart_rdata[UART_TSRE_BIT];
  assign unused_rdata_bits = ^{uart_rdata[15:14], uart_rdata[11:9]};

  assign tx_pop       = (tx_state_q == T_LOAD);
  assign rx_push      = rx_valid_q && rx_frame_q[UART_STOP_BIT];
  assign rx_bad_frame = rx_valid_q && !rx_frame_q[UART_STOP_BIT];

  staticio_fifo #(
    .DEPTH_LOG2 (DEPTH_LOG2),
    .WIDTH      (8)
  ) u_tx_fifo (
    .clk       (clk),
    .reset_n   (reset_n),
    .push      (tx_wr),
    .push_data (tx_data),
    .pop       (tx_pop),
    .head_data (tx_head),
    .full      (tx_full),
    .empty     (tx_empty),
    .count     (tx_count),
    .ovf       (tx_push_ovf)
  );

  staticio_fifo #(
    .DEPTH_LOG2 (DEPTH_LOG2),
    .WIDTH      (8)
  ) u_rx_fifo (
    .clk       (clk),
    .reset_n   (reset_n),
    .push      (rx_push),
    .push_data (rx_frame_q[7:0]),
    .pop       (rx_rd),
    .head_data (rx_data),
    .full      (rx_full_unused),
    .empty     (rx_empty),
    .count     (rx_count),
    .ovf       (rx_push_ovf)
  );

  // The strobe and frame word are registered off the next state so the load
  // pulse lines up exactly with the single cycle spent in T_LOAD.
  always_comb begin
    tx_state_d = tx_state_q;
    case (tx_state_q)
      T_IDLE:  if (!tx_empty && uart_tbe && uart_tsre) tx_state_d = T_LOAD;
      T_LOAD:  tx_state_d = T_START;
      T_START: if (!uart_tsre) tx_state_d = T_BUSY;
      T_BUSY:  if (uart_tsre) tx_state_d = T_IDLE;
      default: tx_state_d = T_IDLE;
    endcase
    uart_tdata_d = (tx_state_d == T_LOAD);
    uart_wdata_d = (tx_state_d == T_LOAD) ? tx_frame_word(tx_head) : uart_wdata_q;
  end

  // A fresh error in the same cycle as err_clr must win.
  always_comb begin
    rx_valid_d  = uart_rxint;
    rx_frame_d  = uart_rxint ? uart_rdata[8:0] : rx_frame_q;
    tx_ovf_d    = (tx_ovf_q && !err_clr) || tx_push_ovf;
    rx_ovf_d    = (rx_ovf_q && !err_clr) || rx_push_ovf;
    frame_err_d = (frame_err_q && !err_clr) || rx_bad_frame;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      tx_state_q   <= T_IDLE;
      uart_tdata_q <= 1'b0;
      uart_wdata_q <= 16'h0000;
      rx_valid_q   <= 1'b0;
      rx_frame_q   <= '0;
      tx_ovf_q     <= 1'b0;
      rx_ovf_q     <= 1'b0;
      frame_err_q  <= 1'b0;
    end else begin
      tx_state_q   <= tx_state_d;
      uart_tdata_q <= uart_tdata_d;
      uart_wdata_q <= uart_wdata_d;
      rx_valid_q   <= rx_valid_d;
      rx_frame_q   <= rx_frame_d;
      tx_ovf_q     <= tx_ovf_d;
      rx_ovf_q     <= rx_ovf_d;
      frame_err_q  <= frame_err_d;
    end
  end

  assign uart_tdata = uart_tdata_q;
  assign uart_wdata = uart_wdata_q;
  assign tx_ovf     = tx_ovf_q;
  assign rx_ovf     = rx_ovf_q;
  assign frame_err  = frame_err_q;

endmodule
